// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C-facing blocks: the register-bank phase
// encoding, a constant-evaluable ceiling-log2 helper and the default bus-idle
// timeout used when a block is instantiated without overriding it.
// ---------------------------------------------------------------------------
package i2c_pkg;

    // PTR_WAIT: the next written byte selects the register pointer.
    // DATA:     written bytes go to the register at the pointer.
    typedef enum logic {
        PTR_WAIT = 1'b0,
        DATA     = 1'b1
    } phase_e;

    localparam int DEFAULT_IDLE_TIMEOUT = 50000;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_idle_timer.sv
// ---------------------------------------------------------------------------
// i2c_idle_timer
// Counts clock cycles since the last bus activity. The count saturates at
// TIMEOUT, and timeout_o pulses for exactly one cycle when it first gets
// there, so a consumer sees one event per idle period.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clear_i   in   bus activity seen this cycle; restarts the count
//   timeout_o out  one-cycle pulse in the first cycle the count equals TIMEOUT
// ---------------------------------------------------------------------------
module i2c_idle_timer
    import i2c_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int CW = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          timeout_q, timeout_d;

    // The pulse is registered from "about to reach the limit". It therefore
    // lines up with the first cycle in which count_q holds the limit.
    always_comb begin
        count_d   = count_q;
        timeout_d = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end
        if (!clear_i && (count_q == LIMIT_M1)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// ---------------------------------------------------------------------------
// i2c_reg_bank
// Byte-addressed register bank behind the I2C slave's byte interface.
// The first byte written in a transaction sets the pointer. Later bytes are
// written at the pointer, and the pointer auto-increments modulo NUM_REGS.
// A read returns the byte prefetched from the pointer, post-increments the
// pointer and ends the transaction. A bus-idle timeout also ends it.
//
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   read_req         in   one-cycle read pulse; data_to_master sampled here
//   data_valid       in   one-cycle pulse; data_from_master is valid
//   data_from_master in   8-bit byte written by the master
//   data_to_master   out  8-bit prefetched byte for the next read
//   status_in        in   NUM_REGS*8 read-only values (byte i used where
//                         WRITABLE_MASK[i]=0)
//   regs_out         out  NUM_REGS*8 writable contents, 0 for read-only slots
//   wr_strobe        out  NUM_REGS one-cycle pulse on bit i when reg i written
// ---------------------------------------------------------------------------
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int                    NUM_REGS      = 16,
    parameter logic [NUM_REGS-1:0]   WRITABLE_MASK = 16'h00FF,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUE   = '0,
    parameter int                    IDLE_TIMEOUT  = DEFAULT_IDLE_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_req,
    input  logic                    data_valid,
    input  logic [7:0]              data_from_master,
    output logic [7:0]              data_to_master,
    input  logic [NUM_REGS*8-1:0]   status_in,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic [NUM_REGS-1:0]     wr_strobe
);

    localparam int PW = clog2(NUM_REGS);

    phase_e              phase_q, phase_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                write_en;
    logic                idle_timeout;

    i2c_idle_timer #(
        .TIMEOUT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (data_valid | read_req),
        .timeout_o (idle_timeout)
    );

    // Phase and pointer. When a write and a read coincide, the write decides
    // the pointer and the read still closes the transaction. The idle
    // timeout only matters in a cycle with no activity. The pointer width
    // equals log2(NUM_REGS), so +1 wraps on its own.
    always_comb begin
        phase_d  = phase_q;
        ptr_d    = ptr_q;
        write_en = 1'b0;
        if (data_valid) begin
            if (phase_q == PTR_WAIT) begin
                ptr_d = data_from_master[PW-1:0];
            end else begin
                write_en = WRITABLE_MASK[ptr_q];
                ptr_d    = ptr_q + 1'b1;
            end
            phase_d = DATA;
        end
        if (read_req) begin
            if (!data_valid) begin
                ptr_d = ptr_q + 1'b1;
            end
            phase_d = PTR_WAIT;
        end else if (!data_valid && idle_timeout) begin
            phase_d = PTR_WAIT;
        end
    end

    // Register array update, strobe, and the prefetched read byte. The read
    // byte is taken from the current pointer, so it trails any pointer or
    // register change by one cycle.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        wr_strobe_d = '0;
        if (write_en) begin
            regs_d[ptr_q]      = data_from_master;
            wr_strobe_d[ptr_q] = 1'b1;
        end
        rd_data_d = WRITABLE_MASK[ptr_q] ? regs_q[ptr_q]
                                         : status_in[{ptr_q, 3'b000} +: 8];
    end

    // Read-only slots are held at zero. Write enables never reach them.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PTR_WAIT;
            ptr_q       <= '0;
            wr_strobe_q <= '0;
            rd_data_q   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= WRITABLE_MASK[i] ? RESET_VALUE[8*i +: 8] : 8'h00;
            end
        end else begin
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
            wr_strobe_q <= wr_strobe_d;
            rd_data_q   <= rd_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = WRITABLE_MASK[g] ? regs_q[g] : 8'h00;
    end

    assign wr_strobe      = wr_strobe_q;
    assign data_to_master = rd_data_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_bank
// Directed scenarios followed by randomized traffic. A behavioural model of
// the register-bank protocol (array, integer pointer, flag, idle count)
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_i2c_reg_bank;

    localparam int             NUM_REGS  = 16;
    localparam logic [15:0]    MASK      = 16'h80FF;
    localparam logic [127:0]   RESET_IMG = 128'hF0E0D0C0B0A090807060504030201000;
    localparam int             TIMEOUT   = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         read_req = 1'b0;
    logic         data_valid = 1'b0;
    logic [7:0]   data_from_master = 8'h00;
    logic [127:0] status_in = '0;
    logic [7:0]   data_to_master;
    logic [127:0] regs_out;
    logic [15:0]  wr_strobe;

    int checks = 0;
    int errors = 0;

    i2c_reg_bank #(
        .NUM_REGS      (NUM_REGS),
        .WRITABLE_MASK (MASK),
        .RESET_VALUE   (RESET_IMG),
        .IDLE_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .read_req         (read_req),
        .data_valid       (data_valid),
        .data_from_master (data_from_master),
        .data_to_master   (data_to_master),
        .status_in        (status_in),
        .regs_out         (regs_out),
        .wr_strobe        (wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Behavioural model state.
    logic [7:0]   mdlMem [NUM_REGS];
    int           mdlPtr = 0;
    bit           mdlExpectPtr = 1'b1;
    int           mdlIdle = 0;
    int           nextPtr;
    bit           nextExpectPtr;
    logic [7:0]   expDtm = 8'h00;
    logic [15:0]  expStrobe = '0;
    logic [127:0] expRegs;
    bit           modelLive = 1'b0;

    // Advance the model on each edge using the inputs that the edge samples.
    // Then compare all outputs just after the edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mdlMem[i] = MASK[i] ? RESET_IMG[8*i +: 8] : 8'h00;
            end
            mdlPtr       = 0;
            mdlExpectPtr = 1'b1;
            mdlIdle      = 0;
            expDtm       = 8'h00;
            expStrobe    = '0;
            modelLive    = 1'b1;
        end else if (modelLive) begin
            expDtm        = MASK[mdlPtr] ? mdlMem[mdlPtr] : status_in[mdlPtr*8 +: 8];
            expStrobe     = '0;
            nextPtr       = mdlPtr;
            nextExpectPtr = mdlExpectPtr;
            if (data_valid) begin
                if (mdlExpectPtr) begin
                    nextPtr = int'(data_from_master) % NUM_REGS;
                end else begin
                    if (MASK[mdlPtr]) begin
                        mdlMem[mdlPtr]    = data_from_master;
                        expStrobe[mdlPtr] = 1'b1;
                    end
                    nextPtr = (mdlPtr + 1) % NUM_REGS;
                end
                nextExpectPtr = 1'b0;
            end
            if (read_req) begin
                if (!data_valid) nextPtr = (mdlPtr + 1) % NUM_REGS;
                nextExpectPtr = 1'b1;
            end else if (!data_valid && mdlIdle >= TIMEOUT) begin
                nextExpectPtr = 1'b1;
            end
            if (data_valid || read_req) mdlIdle = 0;
            else if (mdlIdle < TIMEOUT) mdlIdle = mdlIdle + 1;
            mdlPtr       = nextPtr;
            mdlExpectPtr = nextExpectPtr;
        end
        if (modelLive) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                expRegs[8*i +: 8] = MASK[i] ? mdlMem[i] : 8'h00;
            end
            #1;
            checkOutput("cycle data_to_master", {120'b0, data_to_master}, {120'b0, expDtm});
            checkOutput("cycle wr_strobe", {112'b0, wr_strobe}, {112'b0, expStrobe});
            checkOutput("cycle regs_out", regs_out, expRegs);
        end
    end

    // Stimulus helpers. Each one is entered and left on a falling edge.
    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic [15:0] strobeSeen);
        data_valid       = 1'b1;
        data_from_master = b;
        @(negedge clk);
        data_valid = 1'b0;
        strobeSeen = wr_strobe;
    endtask

    task automatic readByte(output logic [7:0] v);
        read_req = 1'b1;
        v        = data_to_master;
        @(negedge clk);
        read_req = 1'b0;
    endtask

    // One cycle of randomized traffic. Occasionally the bus goes quiet long
    // enough to trigger the idle timeout.
    task automatic applyStimulus();
        int r;
        r                = $urandom_range(0, 99);
        data_valid       = (r < 20);
        read_req         = (r >= 20 && r < 28) || (r == 0);
        data_from_master = 8'($urandom);
        rst              = ($urandom_range(0, 599) == 0);
        if (r == 50) status_in[8*$urandom_range(0, 15) +: 8] = 8'($urandom);
        @(negedge clk);
        data_valid = 1'b0;
        read_req   = 1'b0;
        rst        = 1'b0;
        if (r == 99) idleCycles(TIMEOUT + $urandom_range(0, 5));
    endtask

    logic [15:0] s;
    logic [7:0]  v;

    initial begin
        status_in            = {$urandom, $urandom, $urandom, $urandom};
        status_in[87:80]     = 8'h5A;
        status_in[95:88]     = 8'hC3;
        rst = 1'b1;
        idleCycles(3);
        rst = 1'b0;

        checkOutput("reset regs_out", regs_out, 128'hF000000000000000_7060504030201000);
        checkOutput("reset data_to_master", {120'b0, data_to_master}, 128'h0);
        checkOutput("reset wr_strobe", {112'b0, wr_strobe}, 128'h0);

        // Pointer byte followed by two data bytes.
        writeByte(8'h03, s);
        checkOutput("pointer byte no strobe", {112'b0, s}, 128'h0);
        writeByte(8'hAA, s);
        checkOutput("strobe reg3", {112'b0, s}, 128'h0008);
        writeByte(8'h55, s);
        checkOutput("strobe reg4", {112'b0, s}, 128'h0010);
        checkOutput("reg3 value", {120'b0, regs_out[31:24]}, 128'hAA);
        checkOutput("reg4 value", {120'b0, regs_out[39:32]}, 128'h55);
        idleCycles(2);
        readByte(v);
        checkOutput("ptr after writes reads reg5", {120'b0, v}, 128'h50);

        // Set the pointer, then read twice with the auto-increment.
        idleCycles(2);
        writeByte(8'h03, s);
        idleCycles(2);
        readByte(v);
        checkOutput("read reg3", {120'b0, v}, 128'hAA);
        idleCycles(20);
        readByte(v);
        checkOutput("read reg4", {120'b0, v}, 128'h55);
        idleCycles(2);
        readByte(v);
        checkOutput("read reg5 after two reads", {120'b0, v}, 128'h50);

        // Read-only slot 10.
        idleCycles(2);
        writeByte(8'h0A, s);
        checkOutput("pointer 0x0A no strobe", {112'b0, s}, 128'h0);
        writeByte(8'hFF, s);
        checkOutput("read-only write no strobe", {112'b0, s}, 128'h0);
        idleCycles(2);
        readByte(v);
        checkOutput("read status byte 11", {120'b0, v}, 128'hC3);
        idleCycles(2);
        writeByte(8'h0A, s);
        idleCycles(2);
        readByte(v);
        checkOutput("read status byte 10", {120'b0, v}, 128'h5A);
        checkOutput("read-only regs_out byte 10", {120'b0, regs_out[87:80]}, 128'h0);

        // Pointer masking and wrap from 15 to 0.
        idleCycles(2);
        writeByte(8'h1F, s);
        writeByte(8'h11, s);
        checkOutput("strobe reg15", {112'b0, s}, 128'h8000);
        writeByte(8'h22, s);
        checkOutput("strobe reg0 after wrap", {112'b0, s}, 128'h0001);
        checkOutput("reg15 value", {120'b0, regs_out[127:120]}, 128'h11);
        checkOutput("reg0 value", {120'b0, regs_out[7:0]}, 128'h22);
        idleCycles(2);
        readByte(v);
        checkOutput("ptr after wrap reads reg1", {120'b0, v}, 128'h10);

        // Idle timeout starts a new transaction.
        idleCycles(2);
        writeByte(8'h02, s);
        writeByte(8'h77, s);
        idleCycles(TIMEOUT + 2);
        writeByte(8'h06, s);
        checkOutput("post-timeout pointer no strobe", {112'b0, s}, 128'h0);
        writeByte(8'h88, s);
        checkOutput("strobe reg6", {112'b0, s}, 128'h0040);
        checkOutput("reg2 value", {120'b0, regs_out[23:16]}, 128'h77);
        checkOutput("reg6 value", {120'b0, regs_out[55:48]}, 128'h88);
        checkOutput("reg3 untouched by pointer", {120'b0, regs_out[31:24]}, 128'hAA);

        // Reset in the middle of a transaction.
        idleCycles(2);
        readByte(v);
        checkOutput("read reg7", {120'b0, v}, 128'h70);
        idleCycles(2);
        writeByte(8'h01, s);
        writeByte(8'h33, s);
        checkOutput("strobe reg1", {112'b0, s}, 128'h0002);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reg1 back to reset", {120'b0, regs_out[15:8]}, 128'h10);
        writeByte(8'h44, s);
        checkOutput("post-reset byte is pointer", {112'b0, s}, 128'h0);
        writeByte(8'h99, s);
        checkOutput("strobe reg4 post-reset", {112'b0, s}, 128'h0010);
        checkOutput("reg4 post-reset value", {120'b0, regs_out[39:32]}, 128'h99);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus();
        end
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
